// File: rtl/bcd_display_scanner_if.sv
// Display-side bundle for bcd_display_scanner: BCD capture inputs and
// the multiplexed 7-segment drive outputs.
interface bcd_display_scanner_if #(
  parameter int unsigned NUM_DIGITS = 9
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   bcd_in;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output load, bcd_in,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, bcd_in,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Double-buffered, time-multiplexed common-anode 7-segment scanner for packed BCD digits.
// Optional LEADING_ZERO_BLANK_EN macro blanks leading zero digits (digit 0 always shown).
module bcd_display_scanner #(
  parameter int unsigned NUM_DIGITS   = 9,
  parameter int unsigned ON_CYCLES    = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned DP_POS       = 9
) (
  input logic               Clk,
  input logic               Reset,
  bcd_display_scanner_if.slave bus
);

  localparam int unsigned CntMax = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS + 1);

  typedef enum logic [0:0] {StBlank, StOn} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic [4*NUM_DIGITS-1:0] display_q;
  logic [4*NUM_DIGITS-1:0] pending_q;
  logic                    pend_flag_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic                    frame_done_q;

  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [6:0]              seg_lit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign cur_digit = display_q[4*idx_q +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic all_zero;
  // Walk down from the top digit; a digit is blanked while everything above it is zero.
  always_comb begin
    all_zero = 1'b1;
    lz_blank = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      all_zero    = all_zero && (display_q[4*i +: 4] == 4'd0);
      lz_blank[i] = all_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign seg_lit = lz_blank[idx_q] ? 7'h7F : decode(cur_digit);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StBlank;
      cnt_q        <= '0;
      idx_q        <= '0;
      display_q    <= '0;
      pending_q    <= '0;
      pend_flag_q  <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.load) begin
        pending_q   <= bus.bcd_in;
        pend_flag_q <= 1'b1;
      end
      case (state_q)
        StBlank: begin
          if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= StOn;
            an_q    <= ~(NUM_DIGITS'(1) << idx_q);
            seg_q   <= seg_lit;
            dp_q    <= !(32'(idx_q) == DP_POS);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StOn: begin
          if (cnt_q == CntW'(ON_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= StBlank;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
              idx_q        <= '0;
              frame_done_q <= 1'b1;
              // A load in this same cycle re-arms the flag with the new value.
              if (pend_flag_q) begin
                display_q <= pending_q;
                if (!bus.load) pend_flag_q <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StBlank;
      endcase
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: two instances (decimal point off / on digit 2) checked
// every cycle against a timeline model derived from elapsed cycles since reset.
module tb_bcd_display_scanner;

  localparam int ON    = 4;
  localparam int BLANK = 2;
  localparam int FRAME = 9 * (ON + BLANK);

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [35:0] bcd_in;

  always #5 clk = ~clk;

  bcd_display_scanner_if #(.NUM_DIGITS(9)) ifa ();
  bcd_display_scanner_if #(.NUM_DIGITS(9)) ifb ();

  assign ifa.load   = load;
  assign ifa.bcd_in = bcd_in;
  assign ifb.load   = load;
  assign ifb.bcd_in = bcd_in;

  bcd_display_scanner #(
    .NUM_DIGITS(9), .ON_CYCLES(ON), .BLANK_CYCLES(BLANK), .DP_POS(9)
  ) dut_a (
    .Clk(clk), .Reset(reset), .bus(ifa)
  );

  bcd_display_scanner #(
    .NUM_DIGITS(9), .ON_CYCLES(ON), .BLANK_CYCLES(BLANK), .DP_POS(2)
  ) dut_b (
    .Clk(clk), .Reset(reset), .bus(ifb)
  );

  wire [35:0] obs = {ifa.an, ifa.seg, ifa.dp, ifa.frame_done,
                     ifb.an, ifb.seg, ifb.dp, ifb.frame_done};
  localparam logic [35:0] RstVec = {9'h1FF, 7'h7F, 1'b1, 1'b0, 9'h1FF, 7'h7F, 1'b1, 1'b0};

  logic [6:0]  dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                            7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          t        = 0;
  logic [35:0] m_disp, m_pend;
  logic        m_flag;
  logic [35:0] exp_vec;
  logic [6:0]  zero_hi_seg;

  // One clock: drive inputs, advance the reference timeline, settle outputs.
  task automatic tick(input logic rst, input logic ld, input logic [35:0] din);
    int         dig;
    logic [8:0] e_an;
    logic [6:0] e_seg;
    logic       e_dpb, e_fd;
    reset = rst; load = ld; bcd_in = din;
    @(posedge clk);
    e_an = '1; e_seg = 7'h7F; e_dpb = 1'b1; e_fd = 1'b0;
    if (rst) begin
      t = 0; m_disp = '0; m_pend = '0; m_flag = 1'b0;
    end else begin
      t++;
      if (t % FRAME == 0) begin
        e_fd = 1'b1;
        if (m_flag) begin m_disp = m_pend; m_flag = 1'b0; end
      end
      if (ld) begin m_pend = din; m_flag = 1'b1; end
      if (t >= BLANK && ((t - BLANK) % (BLANK + ON)) < ON) begin
        dig   = ((t - BLANK) % FRAME) / (BLANK + ON);
        e_an  = ~(9'd1 << dig);
        e_seg = dec[m_disp[4*dig +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
        if (dig > 0 && (m_disp >> (4 * dig)) == 36'd0) e_seg = 7'h7F;
`endif
        e_dpb = (dig == 2) ? 1'b0 : 1'b1;
      end
    end
    exp_vec = {e_an, e_seg, 1'b1, e_fd, e_an, e_seg, e_dpb, e_fd};
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 36'h987654321);
      n_checks++;
      if (obs !== RstVec) begin
        n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs, RstVec);
      end
    end
    for (int c = 1; c <= 110; c++) begin
      tick(1'b0, 1'b0, '0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL reset_scan t=%0d got=%h exp=%h", t, obs, exp_vec);
      end
      if (ifa.frame_done) pulses++;
      if (t == 2) begin
        n_checks++;
        if ({ifa.an, ifa.seg} !== {9'h1FE, 7'b1000000}) begin
          n_fail++; $display("FAIL first_digit got=%h exp=%h", {ifa.an, ifa.seg},
                             {9'h1FE, 7'b1000000});
        end
      end
    end
    n_checks++;
    if (pulses !== 2) begin
      n_fail++; $display("FAIL frame_done_count got=%0d exp=2", pulses);
    end
  endtask

  task automatic test_load_wrap();
    tick(1'b1, 1'b0, '0);
    for (int c = 1; c <= 120; c++) begin
      tick(1'b0, c == 10, 36'h123456789);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL load_wrap t=%0d got=%h exp=%h", t, obs, exp_vec);
      end
      if (c == 50 || c == 56 || c == 104) begin
        n_checks++;
        if (ifa.seg !== ((c == 50) ? zero_hi_seg : (c == 56) ? 7'b0010000 : 7'b1111001)) begin
          n_fail++; $display("FAIL load_wrap_seg t=%0d got=%b", t, ifa.seg);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] d;
    tick(1'b1, 1'b0, '0);
    for (int c = 1; c <= 170; c++) begin
      d = (c == 5) ? 36'h111111111 : (c == 20) ? 36'h222222222 : 36'h333333333;
      tick(1'b0, c == 5 || c == 20 || c == 54, d);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL back_to_back t=%0d got=%h exp=%h", t, obs, exp_vec);
      end
      if (c == 56 || c == 110) begin
        n_checks++;
        if (ifa.seg !== ((c == 56) ? 7'b0100100 : 7'b0110000)) begin
          n_fail++; $display("FAIL latest_wins t=%0d got=%b", t, ifa.seg);
        end
      end
    end
  endtask

  task automatic test_invalid_dp();
    logic [35:0] d;
    d = {4'($urandom), $urandom};
    d[15:12] = 4'hA;
    tick(1'b1, 1'b0, '0);
    for (int c = 1; c <= 120; c++) begin
      tick(1'b0, c == 1, d);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL invalid_dp t=%0d got=%h exp=%h", t, obs, exp_vec);
      end
      if (c == 74) begin
        n_checks++;
        if ({ifa.an[3], ifa.seg} !== {1'b0, 7'b0111111}) begin
          n_fail++; $display("FAIL dash got=%b exp=0_0111111", {ifa.an[3], ifa.seg});
        end
      end
      if (c == 14) begin
        n_checks++;
        if ({ifa.dp, ifb.dp, ifb.an[2]} !== 3'b100) begin
          n_fail++; $display("FAIL dp_pos got=%b exp=100", {ifa.dp, ifb.dp, ifb.an[2]});
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    tick(1'b1, 1'b0, '0);
    for (int c = 1; c <= 87; c++) begin
      tick(1'b0, c == 1, 36'h987654321);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL mid_scan_pre t=%0d got=%h exp=%h", t, obs, exp_vec);
      end
    end
    tick(1'b1, 1'b0, '0);
    n_checks++;
    if (obs !== RstVec) begin
      n_fail++; $display("FAIL mid_scan_reset got=%h exp=%h", obs, RstVec);
    end
    for (int c = 1; c <= 60; c++) begin
      tick(1'b0, 1'b0, '0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL mid_scan_post t=%0d got=%h exp=%h", t, obs, exp_vec);
      end
      if (c == 2 || c == 50) begin
        n_checks++;
        if (ifa.seg !== ((c == 2) ? 7'b1000000 : zero_hi_seg)) begin
          n_fail++; $display("FAIL mid_scan_cleared t=%0d got=%b", t, ifa.seg);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    tick(1'b1, 1'b0, '0);
    for (int c = 1; c <= 170; c++) begin
      tick(1'b0, c == 3 || c == 60, (c == 3) ? 36'h000000042 : 36'h0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL leading_zero t=%0d got=%h exp=%h", t, obs, exp_vec);
      end
      if (c == 56 || c == 62 || c == 68 || c == 110) begin
        n_checks++;
        if (ifa.seg !== ((c == 56) ? 7'b0100100 : (c == 62) ? 7'b0011001 :
                         (c == 68) ? zero_hi_seg : 7'b1000000)) begin
          n_fail++; $display("FAIL leading_zero_seg t=%0d got=%b", t, ifa.seg);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [35:0] d;
    tick(1'b1, 1'b0, '0);
    for (int c = 0; c < 600; c++) begin
      d = {4'($urandom), $urandom};
      if ($urandom_range(0, 1) == 0) d = d & 36'h777777777;
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 14) == 0, d);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL random t=%0d got=%h exp=%h", t, obs, exp_vec);
      end
    end
  endtask

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    zero_hi_seg = 7'h7F;
`else
    zero_hi_seg = 7'b1000000;
`endif
    reset = 1'b1; load = 1'b0; bcd_in = '0;
    m_disp = '0; m_pend = '0; m_flag = 1'b0; exp_vec = RstVec;
    test_reset();
    test_load_wrap();
    test_back_to_back();
    test_invalid_dp();
    test_reset_mid_scan();
    test_leading_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
